// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
// Shares the single register-file write port between the pipeline writeback
// stage (requester A, normal priority) and a secondary producer (requester B,
// protected against starvation). The winning request is registered onto
// write_register / write_data / RegWrite_out one cycle after the handshake.
// hazard flags a decode read address that matches the write in flight.
//
// Optional feature macro: REGFILE_R0_HARDWIRED_EN
//   defined   -> register 0 is read-only zero: writes to it still handshake,
//                but never raise RegWrite_out and never report a hazard.
//   undefined -> register 0 behaves like any other register.

module regfile_wb_arbiter #(
  parameter int DATA_W       = 16,
  parameter int ADDR_W       = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  output logic              a_ready,
  input  logic [ADDR_W-1:0] a_reg,
  input  logic [DATA_W-1:0] a_data,
  input  logic              b_valid,
  output logic              b_ready,
  input  logic [ADDR_W-1:0] b_reg,
  input  logic [DATA_W-1:0] b_data,
  input  logic [ADDR_W-1:0] q_reg_1,
  input  logic [ADDR_W-1:0] q_reg_2,
  output logic [ADDR_W-1:0] write_register,
  output logic [DATA_W-1:0] write_data,
  output logic              RegWrite_out,
  output logic              hazard,
  output logic              force_b
);

  // Counter just wide enough to hold STARVE_LIMIT itself.
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0]  starve_cnt;
  logic              a_fire;
  logic              b_fire;
  logic              write_en;
  logic [ADDR_W-1:0] win_reg;
  logic [DATA_W-1:0] win_data;
  logic              query_match;

  // B takes priority once it has been blocked for STARVE_LIMIT cycles in a row.
  assign force_b = (starve_cnt == LIMIT);

  // Readies never look at the port's own valid, so they are safe to use
  // by a requester deciding whether to present its write.
  assign a_ready = !(force_b && b_valid);
  assign b_ready = !a_valid || force_b;

  // The two ready terms are mutually exclusive whenever both valids are high,
  // so at most one of these fires in any cycle.
  assign a_fire = a_valid && a_ready;
  assign b_fire = b_valid && b_ready;

  // Select the winning request and decide whether it actually writes.
  always_comb begin
    win_reg  = b_reg;
    win_data = b_data;
    write_en = a_fire || b_fire;
    if (a_fire) begin
      win_reg  = a_reg;
      win_data = a_data;
    end
`ifdef REGFILE_R0_HARDWIRED_EN
    if (win_reg == '0) begin
      write_en = 1'b0;
    end
`endif
  end

  // Track how long B has been waiting; cleared when B is served or goes idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!b_valid || b_fire) begin
      starve_cnt <= '0;
    end else if (starve_cnt != LIMIT) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Register the winner onto the register-file port; address/data hold when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      RegWrite_out   <= 1'b0;
      write_register <= '0;
      write_data     <= '0;
    end else begin
      RegWrite_out <= write_en;
      if (write_en) begin
        write_register <= win_reg;
        write_data     <= win_data;
      end
    end
  end

  assign query_match = (write_register == q_reg_1) || (write_register == q_reg_2);

`ifdef REGFILE_R0_HARDWIRED_EN
  assign hazard = RegWrite_out && query_match && (write_register != '0);
`else
  assign hazard = RegWrite_out && query_match;
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Testbench for regfile_wb_arbiter (default parameters, STARVE_LIMIT = 4).
// Expected writes are queued as each request is issued; a monitor running
// alongside pops and compares whenever RegWrite_out is high.
// Honours REGFILE_R0_HARDWIRED_EN for the register-0 expectations.

module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst;
  logic        a_valid;
  logic        a_ready;
  logic [2:0]  a_reg;
  logic [15:0] a_data;
  logic        b_valid;
  logic        b_ready;
  logic [2:0]  b_reg;
  logic [15:0] b_data;
  logic [2:0]  q_reg_1;
  logic [2:0]  q_reg_2;
  logic [2:0]  write_register;
  logic [15:0] write_data;
  logic        RegWrite_out;
  logic        hazard;
  logic        force_b;

  int vectors;
  int miscompares;
  logic [18:0] exp_q[$];

  localparam int WIN_NONE = 0;
  localparam int WIN_A    = 1;
  localparam int WIN_B    = 2;

`ifdef REGFILE_R0_HARDWIRED_EN
  localparam bit R0_HARD = 1'b1;
`else
  localparam bit R0_HARD = 1'b0;
`endif

  regfile_wb_arbiter dut (
    .clk            (clk),
    .rst            (rst),
    .a_valid        (a_valid),
    .a_ready        (a_ready),
    .a_reg          (a_reg),
    .a_data         (a_data),
    .b_valid        (b_valid),
    .b_ready        (b_ready),
    .b_reg          (b_reg),
    .b_data         (b_data),
    .q_reg_1        (q_reg_1),
    .q_reg_2        (q_reg_2),
    .write_register (write_register),
    .write_data     (write_data),
    .RegWrite_out   (RegWrite_out),
    .hazard         (hazard),
    .force_b        (force_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle: drive inputs just after the rising edge, check the
  // combinational outputs, and queue the write the winner should produce.
  task automatic applyStimulus(
    input logic        av, input logic [2:0] ar, input logic [15:0] ad,
    input logic        bv, input logic [2:0] br, input logic [15:0] bd,
    input logic [2:0]  q1, input logic [2:0] q2,
    input logic        exp_a_ready, input logic exp_b_ready,
    input logic        exp_force_b, input logic exp_hazard,
    input int          winner
  );
    @(posedge clk);
    #1;
    a_valid = av; a_reg = ar; a_data = ad;
    b_valid = bv; b_reg = br; b_data = bd;
    q_reg_1 = q1; q_reg_2 = q2;
    #1;
    checkOutput("a_ready", 32'(a_ready), 32'(exp_a_ready));
    checkOutput("b_ready", 32'(b_ready), 32'(exp_b_ready));
    checkOutput("force_b", 32'(force_b), 32'(exp_force_b));
    checkOutput("hazard",  32'(hazard),  32'(exp_hazard));
    if (winner == WIN_A && !(R0_HARD && ar == 3'd0)) exp_q.push_back({ar, ad});
    if (winner == WIN_B && !(R0_HARD && br == 3'd0)) exp_q.push_back({br, bd});
  endtask

  task automatic idleCycle(input logic [2:0] q1, input logic [2:0] q2, input logic exp_hazard);
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b0, 3'd0, 16'h0, q1, q2,
                  1'b1, 1'b1, 1'b0, exp_hazard, WIN_NONE);
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst = 1'b1;
    a_valid = 1'b0; a_reg = 3'd0; a_data = 16'h0;
    b_valid = 1'b0; b_reg = 3'd0; b_data = 16'h0;
    q_reg_1 = 3'd0; q_reg_2 = 3'd0;

    // Monitor: every falling edge, a raised write enable must match the queue head.
    fork
      forever begin
        logic [18:0] head;
        @(negedge clk);
        if (RegWrite_out === 1'b1) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("[TB] FAIL unexpected_write: got reg %0d data %0h, expected no write at %0t",
                     write_register, write_data, $time);
          end else begin
            head = exp_q.pop_front();
            checkOutput("write_register", 32'(write_register), 32'(head[18:16]));
            checkOutput("write_data",     32'(write_data),     32'(head[15:0]));
          end
        end
      end
    join_none

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_RegWrite_out",   32'(RegWrite_out),   32'd0);
    checkOutput("rst_write_register", 32'(write_register), 32'd0);
    checkOutput("rst_write_data",     32'(write_data),     32'd0);
    checkOutput("rst_force_b",        32'(force_b),        32'd0);
    checkOutput("rst_hazard",         32'(hazard),         32'd0);
    rst = 1'b0;

    // Single A write, then the in-flight write hazards on register 3, then clears
    applyStimulus(1'b1, 3'd3, 16'h1234, 1'b0, 3'd0, 16'h0, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, WIN_A);
    idleCycle(3'd3, 3'd0, 1'b1);
    idleCycle(3'd3, 3'd0, 1'b0);

    // B alone is accepted immediately
    applyStimulus(1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 16'hBEEF, 3'd0, 3'd0, 1'b1, 1'b1, 1'b0, 1'b0, WIN_B);
    idleCycle(3'd5, 3'd0, 1'b1);

    // Back-to-back A writes to register 2; hazard on match, none on 4/4
    applyStimulus(1'b1, 3'd2, 16'h0202, 1'b0, 3'd0, 16'h0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, WIN_A);
    applyStimulus(1'b1, 3'd2, 16'h0303, 1'b0, 3'd0, 16'h0, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 1'b1, WIN_A);
    idleCycle(3'd4, 3'd4, 1'b0);

    // Contention: A,A,A,A,B repeating, force_b only on the B cycles
    for (int i = 0; i < 10; i++) begin
      if ((i % 5) == 4)
        applyStimulus(1'b1, 3'd1, 16'hA000 + 16'(i), 1'b1, 3'd6, 16'hB000 + 16'(i), 3'd0, 3'd0,
                      1'b0, 1'b1, 1'b1, 1'b0, WIN_B);
      else
        applyStimulus(1'b1, 3'd1, 16'hA000 + 16'(i), 1'b1, 3'd6, 16'hB000 + 16'(i), 3'd0, 3'd0,
                      1'b1, 1'b0, 1'b0, 1'b0, WIN_A);
    end
    idleCycle(3'd0, 3'd0, 1'b0);

    // Reset mid-operation: three A wins leave the counter at 3 with a write in flight
    for (int i = 0; i < 3; i++)
      applyStimulus(1'b1, 3'd1, 16'hC000 + 16'(i), 1'b1, 3'd6, 16'hD000 + 16'(i), 3'd0, 3'd0,
                    1'b1, 1'b0, 1'b0, 1'b0, WIN_A);
    @(posedge clk);
    #1;
    rst = 1'b1;
    a_valid = 1'b0;
    b_valid = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("mid_rst_RegWrite_out",   32'(RegWrite_out),   32'd0);
    checkOutput("mid_rst_write_register", 32'(write_register), 32'd0);
    checkOutput("mid_rst_write_data",     32'(write_data),     32'd0);
    checkOutput("mid_rst_force_b",        32'(force_b),        32'd0);
    checkOutput("mid_rst_hazard",         32'(hazard),         32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // After release priority is back with A: four A wins before B
    for (int i = 0; i < 5; i++) begin
      if (i == 4)
        applyStimulus(1'b1, 3'd1, 16'hE000 + 16'(i), 1'b1, 3'd6, 16'hF000 + 16'(i), 3'd0, 3'd0,
                      1'b0, 1'b1, 1'b1, 1'b0, WIN_B);
      else
        applyStimulus(1'b1, 3'd1, 16'hE000 + 16'(i), 1'b1, 3'd6, 16'hF000 + 16'(i), 3'd0, 3'd0,
                      1'b1, 1'b0, 1'b0, 1'b0, WIN_A);
    end
    idleCycle(3'd0, 3'd0, 1'b0);

    // Register 0 write: handshakes either way; writes and hazards only when not hardwired
    applyStimulus(1'b1, 3'd0, 16'hFFFF, 1'b0, 3'd0, 16'h0, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, WIN_A);
    idleCycle(3'd0, 3'd7, !R0_HARD);
    idleCycle(3'd0, 3'd7, 1'b0);

    // Every queued write must have been seen by the monitor
    @(posedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Arbiter and sequencer for the single register-file write port in the 16-bit RISC datapath. It shares the port between two writeback requesters:
- **A:** the pipeline writeback stage (normal priority).
- **B:** a secondary producer, e.g. a multicycle unit (starvation-protected).

It registers the winning request onto `write_register` / `write_data` / `RegWrite_out`, which feed the decode stage's register file. It also reports a read-after-write hazard to decode for the cycle in which a write is in flight.

## Interface
Parameters:
- `DATA_W`, 16, write-data width.
- `ADDR_W`, 3, register-address width (8 registers).
- `STARVE_LIMIT`, 4, consecutive B-blocked cycles before B is forced to win. Legal range ≥ 1.

Ports (clock and reset first):
- `clk` — in, 1, single clock, rising edge.
- `rst` — in, 1, reset; asynchronous, active-high.
- `a_valid` — in, 1, requester A has a write.
- `a_ready` — out, 1, A's write accepted this cycle.
- `a_reg` — in, ADDR_W, A destination register.
- `a_data` — in, DATA_W, A write data.
- `b_valid` — in, 1, requester B has a write.
- `b_ready` — out, 1, B's write accepted this cycle.
- `b_reg` — in, ADDR_W, B destination register.
- `b_data` — in, DATA_W, B write data.
- `q_reg_1` — in, ADDR_W, decode read address 1, used for the hazard query.
- `q_reg_2` — in, ADDR_W, decode read address 2, used for the hazard query.
- `write_register` — out, ADDR_W, register-file write address (registered).
- `write_data` — out, DATA_W, register-file write data (registered).
- `RegWrite_out` — out, 1, register-file write enable (registered).
- `hazard` — out, 1, a query address matches the in-flight write.
- `force_b` — out, 1, status: B currently holds priority.

## Operation
- **Transfer:** a transfer on a port occurs when its valid and ready are both 1.
- **Starvation counter `starve_cnt`:**
  - Width is clog2(STARVE_LIMIT+1).
  - Increments when `b_valid && !b_ready`.
  - Clears to 0 on a B transfer or when `b_valid == 0`.
  - Saturates at STARVE_LIMIT.
- **Priority flag:** `force_b = (starve_cnt == STARVE_LIMIT)`.
- **Ready logic (combinational, never dependent on the port's own valid):**
  - `a_ready = !(force_b && b_valid)`.
  - `b_ready = !a_valid || force_b`.
- **Resulting arbitration:**
  - At most one transfer per cycle.
  - Both valid without `force_b`: A wins.
  - Both valid with `force_b`: B wins.
  - Only one valid: that one wins.
- **Output stage:**
  - On a transfer, the winner's reg/data are latched into `write_register` / `write_data` and `RegWrite_out` is set to 1 on the next edge.
  - With no transfer, `RegWrite_out` is set to 0 and the address/data hold their previous values.
- **Hazard:** `hazard = RegWrite_out && (write_register == q_reg_1 || write_register == q_reg_2)`. This is combinational from the registered outputs.
- **Valid changes:** a requester may drop valid without a transfer; nothing is latched for it.

## Timing
- **Reset values:** `RegWrite_out=0`, `write_register=0`, `write_data=0`, `starve_cnt=0`; therefore `force_b=0` and `hazard=0`.
- **Reset mid-operation:** the in-flight write is dropped (`RegWrite_out` clears immediately) and priority returns to A.
- **Latency:** 1 cycle from transfer to `RegWrite_out` high. The register file writes on the following edge.
- **Throughput:** one write per cycle; back-to-back transfers are allowed.
- **Fairness:** with both ports continuously valid and STARVE_LIMIT=N, the pattern is N A-transfers, then 1 B-transfer, repeating.
- **Counter timing:** after a forced B transfer, `starve_cnt` is 0 on the next cycle. A new B request therefore waits at most N cycles again.
- **Same destination:** simultaneous valids targeting the same register get no special handling; only the winner writes.

## Configuration
- Macro: `REGFILE_R0_HARDWIRED_EN`.
- **Defined:**
  - Transfers with destination register 0 still handshake normally.
  - `RegWrite_out` stays 0 for them.
  - `hazard` is never asserted for register 0.
- **Undefined:** register 0 is written like any other register.

## Test plan
- **Single A write:** reset, then `a_valid=1`, `a_reg=3`, `a_data=0x1234` for one cycle → `a_ready=1` that cycle; next cycle `RegWrite_out=1`, `write_register=3`, `write_data=0x1234`; the cycle after, `RegWrite_out=0`.
- **Contention (STARVE_LIMIT=4):** A and B continuously valid with distinct data → grants A,A,A,A,B repeating; `force_b=1` only on the B cycles.
- **B alone:** `b_valid=1`, `b_reg=5`, `b_data=0xBEEF`, `a_valid=0` → `b_ready=1` immediately; next cycle a write to register 5 of 0xBEEF; `starve_cnt` stays 0.
- **Hazard:** in-flight write to register 2, `q_reg_1=2` → `hazard=1`. Same in-flight write with `q_reg_1=q_reg_2=4` → `hazard=0`.
- **Reset mid-operation:** assert `rst` in the cycle where `RegWrite_out=1` and `starve_cnt=3` → `RegWrite_out=0`, `write_register=0`, `write_data=0` immediately. After release, both ports valid gives 4 A-transfers before B.
- **`REGFILE_R0_HARDWIRED_EN` defined:** A write to register 0 of 0xFFFF → `a_ready=1`, `RegWrite_out` stays 0, `hazard=0` with `q_reg_1=0`. Undefined: `RegWrite_out=1` and `hazard=1` in the same setup.
